arith_compare_unit: RTL and testbench
=====================================

// Module: arith_compare_unit
// PURPOSE
//   Parametrised operand-load / arithmetic / compare unit for the board I/O wrappers.
//   Two W-bit operands are loaded from switches by button edges; selectable op (MUL/ADD/SUB).
//   A stored result is committed on a slow tick after the commit switch toggles.
//   LEDs show stored result vs current candidate (lt/eq/gt).
//   Slow timing uses a clock-enable tick on clk only; no derived clocks.
// PARAMETERS
//   W         8    operand width; result/candidate width is 2*W
//   DIV_LOG2  25   tick period = 2**DIV_LOG2 clk cycles (25 -> ~0.34 s at 100 MHz)
//   SIGNED    0    1: operands two's complement, sign-extended; 0: unsigned
// PORTS
//   clk        in   1     system clock, all state on posedge
//   rst_n      in   1     asynchronous reset, active low
//   sw         in   W     operand value from switches (asynchronous)
//   commit_sw  in   1     commit switch; any toggle requests a commit (asynchronous)
//   btn        in   3     [0] load op1, [1] load op2, [2] cycle mode (asynchronous)
//   led        out  3     [0] res<cand, [1] res==cand, [2] res>cand
//   res_o      out  2*W   stored (committed) result
//   mode_o     out  2     current op: 0 MUL, 1 ADD, 2 SUB
//   pending_o  out  1     commit requested, waiting for tick
// BEHAVIOUR
//   Reset (async assert, sync-deassert-safe): op1=op2=0, mode=MUL, cand=0, res=0,
//     counter=0, synchronisers=0, FSM=IDLE -> led=3'b010, res_o=0, mode_o=0, pending_o=0.
//   Inputs: sw, commit_sw, btn each pass a 2-FF synchroniser; sw sampled post-sync.
//   Buttons: act on synchronised rising edge only; a held button acts once.
//     btn0 edge: op1<=sw. btn1 edge: op2<=sw. Both same cycle: both load.
//     btn2 edge: mode MUL->ADD->SUB->MUL; value 3 is never reached.
//   Candidate: cand <= f(op1,op2,mode) every cycle (1-cycle pipeline register).
//     Latency: btn edge at sync output -> op reg +1 -> cand +1 -> led same cycle (comb).
//     MUL: full 2W product. ADD/SUB: operands extended to 2W (zero or sign).
//     Result kept modulo 2**(2W); no saturation, no overflow flag.
//   Compare: res vs cand, signed if SIGNED=1; exactly one led bit high at all times.
//   Tick: DIV_LOG2-bit free-running counter wraps to 0; tick=1 for one cycle at all-ones.
//   Commit FSM (2 states):
//     IDLE    --toggle edge, no tick-->           PENDING
//     IDLE    --toggle edge, tick same cycle-->   res<=cand, stay IDLE
//     PENDING --tick-->                           res<=cand, IDLE
//     PENDING --further toggles-->                stay PENDING (coalesced: one commit)
//   Toggle edge = synchronised commit_sw differs from its previous registered value.
//   pending_o = (state==PENDING).
//   Reset mid-operation: pending request dropped, res cleared, counter restarts.
//   Loads during PENDING: res gets cand as of the tick cycle, not as of the toggle.
// STRUCTURE
//   Package acu_pkg: mode constants MODE_MUL=2'd0, MODE_ADD=2'd1, MODE_SUB=2'd2;
//     FSM state constants ST_IDLE, ST_PENDING.
//   Sub-module sync_edge (params WIDTH): 2-FF sync + registered prev; outputs
//     sync, rise, any_edge per bit. Instances: btn (WIDTH=3), commit_sw (WIDTH=1).
//     sw uses a plain 2-FF sync (no edge detect).
//   Top holds operand/mode regs, cand pipeline reg, tick counter, commit FSM, comparator.
// TESTING (sim with DIV_LOG2=3, W=8)
//   Reset: rst_n=0 -> led=010, res_o=0, mode_o=0, pending_o=0; deassert -> unchanged.
//   MUL load: sw=12,btn0 pulse; sw=10,btn1 pulse -> cand=120, led=001 (0<120);
//     toggle commit_sw -> pending_o=1, at next tick res_o=120, led=010.
//   Held button: btn2 held 50 cycles -> mode_o 0->1 once; release/press -> 2; again -> 0.
//   SUB wrap unsigned: op1=3,op2=5,mode SUB -> cand=16'hFFFE; commit -> res_o=16'hFFFE;
//     SIGNED=1 rerun -> res_o=-2, then op1=0 gives cand=-5, led=100 (res>cand).
//   Coalesce: toggle commit_sw 3 times within one tick window -> exactly one res update;
//     toggle on the tick cycle -> commit same cycle, pending_o stays 0.
//   Reset mid-pending: toggle, assert rst_n before tick -> pending_o=0, res_o=0,
//     no commit on subsequent tick.

Source files
------------

// File: rtl/acu_pkg.sv
// Shared constants for the operand-load / arithmetic / compare unit.
// Mode encodings, commit FSM states and the mode-cycling helper.
package acu_pkg;

  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_SUB = 2'd2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // MUL -> ADD -> SUB -> MUL; the unused code 3 also falls back to MUL
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_MUL: next_mode = MODE_ADD;
      MODE_ADD: next_mode = MODE_SUB;
      default:  next_mode = MODE_MUL;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser per bit plus a registered copy for edge detection.
// Latency: 2 clk to sync, rise/any_edge valid in the cycle sync changes; no backpressure.
// Backpressure: none, free-running.
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] any_edge
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync     = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign any_edge = sync_q ^ prev_q;

endmodule

// File: rtl/arith_compare_unit.sv
// Operand load / MUL-ADD-SUB candidate / tick-committed result with lt-eq-gt LEDs.
// Latency: btn edge -> op reg +1 -> cand +1; commit lands on the next slow tick.
// Backpressure: none; repeated commit toggles while pending coalesce into one commit.
module arith_compare_unit
  import acu_pkg::*;
#(
  parameter int W        = 8,
  parameter int DIV_LOG2 = 25,
  parameter int SIGNED   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   sw,
  input  logic           commit_sw,
  input  logic [2:0]     btn,
  output logic [2:0]     led,
  output logic [2*W-1:0] res_o,
  output logic [1:0]     mode_o,
  output logic           pending_o
);

  localparam logic [DIV_LOG2-1:0] CNT_ONE = {{(DIV_LOG2-1){1'b0}}, 1'b1};

  logic [W-1:0]   sw_meta_q;
  logic [W-1:0]   sw_sync_q;
  logic [2:0]     btn_sync;
  logic [2:0]     btn_rise;
  logic [2:0]     btn_any;
  logic           cs_sync;
  logic           cs_rise;
  logic           cs_toggle;

  logic [W-1:0]   op1_q;
  logic [W-1:0]   op2_q;
  logic [1:0]     mode_q;
  logic [2*W-1:0] cand_d;
  logic [2*W-1:0] cand_q;
  logic [2*W-1:0] res_q;

  logic [DIV_LOG2-1:0] cnt_q;
  logic                tick;

  state_t state_q;
  state_t state_d;
  logic   commit;

  logic   res_lt;
  logic   res_eq;
  logic   res_gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  sync_edge #(.WIDTH(3)) u_btn_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (btn),
    .sync     (btn_sync),
    .rise     (btn_rise),
    .any_edge (btn_any)
  );

  sync_edge #(.WIDTH(1)) u_commit_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (commit_sw),
    .sync     (cs_sync),
    .rise     (cs_rise),
    .any_edge (cs_toggle)
  );

  // Only the edge strobes are consumed; the level/other outputs are intentionally dropped
  logic unused_sync_outputs;
  assign unused_sync_outputs = ^{btn_sync, btn_any, cs_sync, cs_rise};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= '0;
      op2_q  <= '0;
      mode_q <= MODE_MUL;
    end else begin
      if (btn_rise[0]) op1_q <= sw_sync_q;
      if (btn_rise[1]) op2_q <= sw_sync_q;
      if (btn_rise[2]) mode_q <= next_mode(mode_q);
    end
  end

  function automatic logic [2*W-1:0] extend(input logic [W-1:0] v);
    extend = (SIGNED != 0) ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
  endfunction

  // Product of the 2W-bit extended operands truncated to 2W is exact for both signednesses
  always_comb begin
    cand_d = '0;
    case (mode_q)
      MODE_MUL: cand_d = extend(op1_q) * extend(op2_q);
      MODE_ADD: cand_d = extend(op1_q) + extend(op2_q);
      MODE_SUB: cand_d = extend(op1_q) - extend(op2_q);
      default:  cand_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
    end else begin
      cand_q <= cand_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign tick = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_toggle) begin
          if (tick) commit  = 1'b1;
          else      state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Captures the candidate of the commit cycle, so loads made while pending are included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (commit) begin
      res_q <= cand_q;
    end
  end

  always_comb begin
    res_eq = (res_q == cand_q);
    if (SIGNED != 0) begin
      res_lt = $signed(res_q) < $signed(cand_q);
      res_gt = $signed(res_q) > $signed(cand_q);
    end else begin
      res_lt = res_q < cand_q;
      res_gt = res_q > cand_q;
    end
  end

  assign led       = {res_gt, res_eq, res_lt};
  assign res_o     = res_q;
  assign mode_o    = mode_q;
  assign pending_o = (state_q == ST_PENDING);

endmodule

// File: tb/tb_arith_compare_unit.sv
// Directed bench: unsigned and signed instances share stimulus; tick period 8 clk.
module tb_arith_compare_unit;

  localparam int W = 8;
  localparam int DL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sw = '0;
  logic          commit_sw = 1'b0;
  logic [2:0]    btn = '0;

  logic [2:0]    u_led, s_led;
  logic [15:0]   u_res, s_res;
  logic [1:0]    u_mode, s_mode;
  logic          u_pend, s_pend;

  int checks = 0;
  int failures = 0;

  logic [2:0] bcnt;

  always #5 clk = ~clk;

  arith_compare_unit #(.W(W), .DIV_LOG2(DL), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .commit_sw(commit_sw), .btn(btn),
    .led(u_led), .res_o(u_res), .mode_o(u_mode), .pending_o(u_pend)
  );

  arith_compare_unit #(.W(W), .DIV_LOG2(DL), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .commit_sw(commit_sw), .btn(btn),
    .led(s_led), .res_o(s_res), .mode_o(s_mode), .pending_o(s_pend)
  );

  // Tick phase reference: tick fires on the posedge where this count is 7
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 3'd0;
    else        bcnt <= bcnt + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_to(input logic [2:0] ph);
    int k;
    k = 0;
    @(negedge clk);
    while (bcnt !== ph && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bcnt !== ph) begin
      failures++;
      $display("FAIL align_timeout got=%0d exp=%0d", bcnt, ph);
    end
  endtask

  task automatic btn_pulse(input int idx);
    btn[idx] = 1'b1;
    wait_cyc(3);
    btn = '0;
    wait_cyc(4);
  endtask

  task automatic load_op(input int idx, input logic [W-1:0] v);
    sw = v;
    wait_cyc(3);
    btn_pulse(idx);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_cyc(2);
    checks++; if (u_led !== 3'b010) begin failures++; $display("FAIL reset_led got=%b exp=010", u_led); end
    checks++; if (u_res !== 16'd0) begin failures++; $display("FAIL reset_res got=%h exp=0000", u_res); end
    checks++; if (u_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", u_mode); end
    checks++; if (u_pend !== 1'b0 || s_pend !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b%b exp=00", u_pend, s_pend); end
    rst_n = 1'b1;
    wait_cyc(3);
    checks++; if (u_led !== 3'b010 || s_led !== 3'b010) begin failures++; $display("FAIL post_reset_led got=%b/%b exp=010", u_led, s_led); end
    checks++; if (u_res !== 16'd0 || u_pend !== 1'b0 || u_mode !== 2'd0) begin failures++; $display("FAIL post_reset_state got=%h/%b/%0d exp=0000/0/0", u_res, u_pend, u_mode); end
  endtask

  task automatic test_mul;
    load_op(0, 8'd12);
    load_op(1, 8'd10);
    checks++; if (u_led !== 3'b001 || s_led !== 3'b001) begin failures++; $display("FAIL mul_led got=%b/%b exp=001", u_led, s_led); end
    align_to(3'd0);
    commit_sw = ~commit_sw;
    wait_cyc(4);
    checks++; if (u_pend !== 1'b1 || s_pend !== 1'b1) begin failures++; $display("FAIL mul_pending got=%b/%b exp=1", u_pend, s_pend); end
    checks++; if (u_res !== 16'd0) begin failures++; $display("FAIL mul_res_before_tick got=%h exp=0000", u_res); end
    align_to(3'd0);
    checks++; if (u_res !== 16'd120 || s_res !== 16'd120) begin failures++; $display("FAIL mul_commit_res got=%h/%h exp=0078", u_res, s_res); end
    checks++; if (u_led !== 3'b010 || u_pend !== 1'b0) begin failures++; $display("FAIL mul_commit_led got=%b/%b exp=010/0", u_led, u_pend); end
  endtask

  task automatic test_held_button;
    btn[2] = 1'b1;
    wait_cyc(10);
    checks++; if (u_mode !== 2'd1) begin failures++; $display("FAIL held_mode_early got=%0d exp=1", u_mode); end
    wait_cyc(40);
    checks++; if (u_mode !== 2'd1) begin failures++; $display("FAIL held_mode_late got=%0d exp=1", u_mode); end
    btn = '0;
    wait_cyc(4);
    btn_pulse(2);
    checks++; if (u_mode !== 2'd2) begin failures++; $display("FAIL mode_to_sub got=%0d exp=2", u_mode); end
    btn_pulse(2);
    checks++; if (u_mode !== 2'd0 || s_mode !== 2'd0) begin failures++; $display("FAIL mode_wrap got=%0d/%0d exp=0", u_mode, s_mode); end
  endtask

  task automatic test_sub_signed;
    load_op(0, 8'd3);
    load_op(1, 8'd5);
    btn_pulse(2);
    btn_pulse(2);
    checks++; if (u_mode !== 2'd2) begin failures++; $display("FAIL sub_mode got=%0d exp=2", u_mode); end
    // res=120 against cand=0xFFFE: unsigned 120 is smaller, signed 120 > -2
    checks++; if (u_led !== 3'b001 || s_led !== 3'b100) begin failures++; $display("FAIL sub_led got=%b/%b exp=001/100", u_led, s_led); end
    align_to(3'd0);
    commit_sw = ~commit_sw;
    align_to(3'd0);
    checks++; if (u_res !== 16'hFFFE || s_res !== 16'hFFFE) begin failures++; $display("FAIL sub_wrap_res got=%h/%h exp=fffe", u_res, s_res); end
    checks++; if (u_led !== 3'b010 || s_led !== 3'b010) begin failures++; $display("FAIL sub_commit_led got=%b/%b exp=010", u_led, s_led); end
    load_op(0, 8'd0);
    checks++; if (u_led !== 3'b100 || s_led !== 3'b100) begin failures++; $display("FAIL sub_neg5_led got=%b/%b exp=100", u_led, s_led); end
    btn_pulse(2);
    checks++; if (u_led !== 3'b100 || s_led !== 3'b001) begin failures++; $display("FAIL mul_zero_led got=%b/%b exp=100/001", u_led, s_led); end
    btn_pulse(2);
    checks++; if (u_mode !== 2'd1 || u_led !== 3'b100 || s_led !== 3'b001) begin failures++; $display("FAIL add_led got=%0d/%b/%b exp=1/100/001", u_mode, u_led, s_led); end
    align_to(3'd0);
    commit_sw = ~commit_sw;
    align_to(3'd0);
    checks++; if (u_res !== 16'd5 || s_res !== 16'd5) begin failures++; $display("FAIL add_res got=%h/%h exp=0005", u_res, s_res); end
  endtask

  task automatic test_coalesce;
    load_op(0, 8'd7);
    align_to(3'd0);
    commit_sw = ~commit_sw;
    wait_cyc(1);
    commit_sw = ~commit_sw;
    wait_cyc(1);
    commit_sw = ~commit_sw;
    wait_cyc(2);
    checks++; if (u_pend !== 1'b1) begin failures++; $display("FAIL coalesce_pending got=%b exp=1", u_pend); end
    align_to(3'd0);
    checks++; if (u_res !== 16'd12 || u_pend !== 1'b0) begin failures++; $display("FAIL coalesce_res got=%h/%b exp=000c/0", u_res, u_pend); end
    load_op(0, 8'd9);
    wait_cyc(16);
    checks++; if (u_res !== 16'd12 || u_pend !== 1'b0 || u_led !== 3'b001) begin failures++; $display("FAIL coalesce_single got=%h/%b/%b exp=000c/0/001", u_res, u_pend, u_led); end
    // Toggle timed so the synchronised edge coincides with the tick
    align_to(3'd5);
    commit_sw = ~commit_sw;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (u_pend !== 1'b0) begin failures++; $display("FAIL ontick_pending cyc=%0d got=%b exp=0", i, u_pend); end
    end
    checks++; if (u_res !== 16'd14 || u_led !== 3'b010) begin failures++; $display("FAIL ontick_res got=%h/%b exp=000e/010", u_res, u_led); end
  endtask

  task automatic test_reset_mid_pending;
    align_to(3'd0);
    commit_sw = ~commit_sw;
    wait_cyc(4);
    checks++; if (u_pend !== 1'b1) begin failures++; $display("FAIL midrst_pre_pending got=%b exp=1", u_pend); end
    rst_n = 1'b0;
    wait_cyc(1);
    checks++; if (u_pend !== 1'b0 || u_res !== 16'd0 || s_res !== 16'd0) begin failures++; $display("FAIL midrst_cleared got=%b/%h/%h exp=0/0000/0000", u_pend, u_res, s_res); end
    checks++; if (u_mode !== 2'd0 || u_led !== 3'b010) begin failures++; $display("FAIL midrst_mode_led got=%0d/%b exp=0/010", u_mode, u_led); end
    wait_cyc(1);
    rst_n = 1'b1;
    load_op(0, 8'd2);
    load_op(1, 8'd3);
    wait_cyc(16);
    checks++; if (u_res !== 16'd0 || u_pend !== 1'b0 || u_led !== 3'b001) begin failures++; $display("FAIL midrst_no_commit got=%h/%b/%b exp=0000/0/001", u_res, u_pend, u_led); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_held_button;
    test_sub_signed;
    test_coalesce;
    test_reset_mid_pending;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
